barrett_mod_173: RTL and testbench

//  - Pipelined Barrett modular reducer: dout_r = din_a mod 173 for any 15-bit unsigned din_a.
//  - Reduction leaf of the Galois-field systemizer datapath; feeds GF(173) arithmetic units.
//  - Multiply-shift quotient estimate, no divider; fixed latency; one result per clock.

---
 rtl/gf_consts_pkg.sv | 19 +
 rtl/barrett_reduce_comb.sv | 23 ++
 rtl/barrett_mod_173.sv | 61 ++++++
 tb/tb_barrett_mod_173.sv | 133 +++++++++++++
 4 files changed

// File: rtl/gf_consts_pkg.sv
// Shared constants for the GF(173) datapath: modulus, widths and Barrett parameters.
// barrett_m() recomputes the Barrett constant so instantiations can check it at elaboration.
package gf_consts_pkg;

  localparam int Q      = 173;
  localparam int IN_W   = 15;
  localparam int OUT_W  = 8;
  localparam int K      = 16;
  localparam int M      = 378;
  // Residue window: x - q_est*Q is always below 2*Q, so 9 bits hold it exactly.
  localparam int RW     = OUT_W + 1;
  localparam int PROD_W = IN_W + 10;
  localparam int QE_W   = 9;

  function automatic int barrett_m(input int q, input int k);
    return (1 << k) / q;
  endfunction

endpackage

// File: rtl/barrett_reduce_comb.sv
// Combinational Barrett tail: remainder from operand and quotient estimate,
// followed by a single conditional subtraction of the modulus.
module barrett_reduce_comb #(
  parameter int Q     = 173,
  parameter int RW    = 9,
  parameter int OUT_W = 8
) (
  input  logic [RW-1:0]    x,
  input  logic [RW-1:0]    q_est,
  output logic [OUT_W-1:0] r
);

  localparam logic [RW-1:0] QR = RW'(Q);

  logic [RW-1:0] qq;
  logic [RW-1:0] r_raw;

  // The true remainder is below 2^RW, so arithmetic modulo 2^RW on the low bits is exact.
  assign qq    = q_est * QR;
  assign r_raw = x - qq;
  assign r     = (r_raw >= QR) ? OUT_W'(r_raw - QR) : OUT_W'(r_raw);

endmodule

// File: rtl/barrett_mod_173.sv
// Two-stage pipelined reducer: dout_r = din_a mod 173, latency 2, one operand per clock.
// Valid-only stream: in_valid qualifies din_a, out_valid qualifies dout_r; no ready, no stall.
module barrett_mod_173
  import gf_consts_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  din_a,
  output logic             out_valid,
  output logic [OUT_W-1:0] dout_r
);

  if (barrett_m(Q, K) != M) begin : g_bad_m
    $error("Barrett constant M does not match floor(2^K/Q)");
  end

  logic [PROD_W-1:0] prod;
  logic [QE_W-1:0]   q_next;
  logic              v1;
  logic [RW-1:0]     x1;
  logic [QE_W-1:0]   qe1;
  logic [OUT_W-1:0]  r_next;

  assign prod   = PROD_W'(din_a) * PROD_W'(M);
  assign q_next = QE_W'(prod >> K);

  // Only the low RW bits of x are needed downstream since the remainder fits in RW bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1  <= 1'b0;
      x1  <= '0;
      qe1 <= '0;
    end else begin
      v1  <= in_valid;
      x1  <= din_a[RW-1:0];
      qe1 <= q_next;
    end
  end

  barrett_reduce_comb #(
    .Q     (Q),
    .RW    (RW),
    .OUT_W (OUT_W)
  ) u_reduce (
    .x     (x1),
    .q_est (qe1),
    .r     (r_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      dout_r    <= '0;
    end else begin
      out_valid <= v1;
      dout_r    <= r_next;
    end
  end

endmodule

// File: tb/tb_barrett_mod_173.sv
// Bench for barrett_mod_173: directed boundaries, full-range stream with random gaps,
// random operands and an asynchronous mid-stream reset, against x % 173.
module tb_barrett_mod_173;

  localparam int Q = 173;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [14:0] din_a = '0;
  logic        out_valid;
  logic [7:0]  dout_r;

  logic [7:0]  exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cycles = 0;
  logic        vd1, vd2;

  barrett_mod_173 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .din_a     (din_a),
    .out_valid (out_valid),
    .dout_r    (dout_r)
  );

  // clock/reset block
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cycles <= cycles + 1;
    if (cycles > 90000) begin
      $display("FAIL watchdog: cycles=%0d exceeded limit 90000", cycles);
      $fatal(1, "watchdog expired");
    end
  end

  // reference valid pipeline: in_valid as sampled by the DUT, delayed two edges
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      vd1 <= 1'b0;
      vd2 <= 1'b0;
    end else begin
      vd1 <= in_valid;
      vd2 <= vd1;
    end
  end

  // driver tasks
  task automatic drive(input logic v, input int x);
    @(posedge clk);
    #1;
    in_valid = v;
    din_a    = 15'(x);
    if (v) exp_q.push_back(8'(x % Q));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, int'($urandom_range(0, 32767)));
  endtask

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #3;
    rst      = 1'b1;
    in_valid = 1'b0;
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_dout_r", int'(dout_r), 0);
    exp_q.delete();
    @(negedge clk);
    #2;
    rst = 1'b0;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      check("valid_pattern", int'(out_valid), int'(vd2));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          check("result", int'(dout_r), int'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    int dir[7];
    dir = '{173, 346, 29929, 174, 29928, 32767, 32524};
    #1;
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_dout_r", int'(dout_r), 0);
    #20;
    rst = 1'b0;
    idle(2);

    for (int x = 0; x < Q; x++) drive(1'b1, x);
    idle(3);
    foreach (dir[i]) drive(1'b1, dir[i]);
    idle(3);

    for (int x = 0; x < 32768; x++) begin
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
      if (x == 12000) begin
        pulse_reset();
        idle(int'($urandom_range(0, 3)));
      end
      drive(1'b1, x);
    end
    idle(2);

    for (int i = 0; i < 300; i++) drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 32767)));
    idle(4);

    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
